// File: rtl/ahb_rsp_mux_n.sv
// ahb_rsp_mux_n: AHB data-phase response mux for NSLV slaves, with default slave and stall watchdog.
// Latency: zero added cycles while routing; unmapped, multi-hot or timed-out transfers get a 2-cycle ERROR.
// Backpressure: HREADYm follows the routed slave's HREADYOUT; it is held low during ERR1.
// Ports: HSEL/HTRANS are address-phase inputs; HRDATA_s/HREADY_s/HRESP_s are the packed slave
//        responses, with slave k in slice k. HRDATAm/HREADYm/HRESPm go to the master.
//        sel_err/tmo_err are sticky flags cleared by clr; tmo_slv is the last slave that timed out.
module ahb_rsp_mux_n #(
    parameter int NSLV    = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NSLV-1:0]      HSEL,
    input  logic [1:0]           HTRANS,
    input  logic [NSLV*DW-1:0]   HRDATA_s,
    input  logic [NSLV-1:0]      HREADY_s,
    input  logic [2*NSLV-1:0]    HRESP_s,
    input  logic                 clr,
    output logic [DW-1:0]        HRDATAm,
    output logic                 HREADYm,
    output logic [1:0]           HRESPm,
    output logic                 sel_err,
    output logic                 tmo_err,
    output logic [3:0]           tmo_slv
);

    // A zero TIMEOUT still gets a 1-bit counter so that no declaration has zero width.
    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int            LAST_I   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST_I);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam bit            WD_EN    = (TIMEOUT > 0);

    typedef enum logic [1:0] {S_IDLE, S_ROUTE, S_ERR1, S_ERR2} state_t;

    state_t          state;
    state_t          state_nxt;
    state_t          cap_state;
    logic [NSLV-1:0] dsel;
    logic            dact;
    logic [CW-1:0]   cnt;

    logic [DW-1:0]   rt_dat;
    logic            rt_rdy;
    logic [1:0]      rt_resp;
    logic [3:0]      rt_idx;
    logic            sel_multi;
    logic            sel_one;
    logic            in_route;
    logic            tmo_fire;

    // HTRANS[0] only separates NONSEQ from SEQ, which makes no difference to the response path.
    logic            unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    // dsel is one-hot whenever the FSM is in ROUTE, so an AND-OR mux is enough. The same loop
    // encodes the slave index for tmo_slv.
    always_comb begin
        rt_dat  = '0;
        rt_rdy  = 1'b0;
        rt_resp = 2'b00;
        rt_idx  = 4'd0;
        for (int k = 0; k < NSLV; k++) begin
            if (dsel[k]) begin
                rt_dat  = rt_dat  | HRDATA_s[k*DW +: DW];
                rt_rdy  = rt_rdy  | HREADY_s[k];
                rt_resp = rt_resp | HRESP_s[2*k +: 2];
                rt_idx  = rt_idx  | 4'(k);
            end
        end
    end

    // Clearing the lowest set bit leaves a non-zero value only when two or more bits are set.
    assign sel_multi = |(HSEL & (HSEL - NSLV'(1)));
    assign sel_one   = (|HSEL) && !sel_multi;

    assign in_route  = (state == S_ROUTE) && dact;
    assign tmo_fire  = WD_EN && in_route && !rt_rdy && (cnt == CNT_LAST);

    // Destination state for an address phase accepted at this edge.
    always_comb begin
        if (!HTRANS[1])
            cap_state = S_IDLE;
        else if (sel_one)
            cap_state = S_ROUTE;
        else
            cap_state = S_ERR1;
    end

    // FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_ERR2: state_nxt = cap_state;
            S_ROUTE: begin
                if (HREADYm)
                    state_nxt = cap_state;
                else if (tmo_fire)
                    state_nxt = S_ERR1;
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs. ROUTE is purely combinational from the slave, including a slave's own ERROR.
    always_comb begin
        HRDATAm = '0;
        HREADYm = 1'b1;
        HRESPm  = 2'b00;
        unique case (state)
            S_ROUTE: begin
                if (dact) begin
                    HRDATAm = rt_dat;
                    HREADYm = rt_rdy;
                    HRESPm  = rt_resp;
                end
            end
            S_ERR1: begin
                HREADYm = 1'b0;
                HRESPm  = 2'b01;
            end
            S_ERR2:  HRESPm = 2'b01;
            default: ;
        endcase
    end

    // Address-phase capture, wait counter and sticky flags. A flag set beats clr in the same cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel    <= '0;
            dact    <= 1'b0;
            cnt     <= '0;
            sel_err <= 1'b0;
            tmo_err <= 1'b0;
            tmo_slv <= 4'd0;
        end else begin
            if (HREADYm) begin
                dsel <= HSEL;
                dact <= HTRANS[1];
                cnt  <= '0;
            end else if (in_route && !rt_rdy && (cnt != CNT_MAX)) begin
                // Saturate rather than wrap: with the watchdog off, a stuck slave must not
                // make the count roll over.
                cnt <= cnt + CW'(1);
            end

            if (HREADYm && HTRANS[1] && sel_multi)
                sel_err <= 1'b1;
            else if (clr)
                sel_err <= 1'b0;

            if (tmo_fire) begin
                tmo_err <= 1'b1;
                tmo_slv <= rt_idx;
            end else if (clr) begin
                tmo_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_rsp_mux_n.sv
// tb_ahb_rsp_mux_n: bench for ahb_rsp_mux_n with NSLV=4, DW=32. The main instance has TIMEOUT=4; a second instance has TIMEOUT=0.
// Each transfer's expected completion (wait count, response, data, flags) goes into a queue; a monitor checks it.
// Slaves not being addressed drive random responses; address inputs carry random junk during wait states.
module tb_ahb_rsp_mux_n;

    localparam int NSLV = 4;
    localparam int DW   = 32;
    localparam int TMO  = 4;

    logic                HCLK = 1'b0;
    logic                HRESETn;
    logic [NSLV-1:0]     HSEL;
    logic [1:0]          HTRANS;
    logic [NSLV*DW-1:0]  HRDATA_s;
    logic [NSLV-1:0]     HREADY_s;
    logic [2*NSLV-1:0]   HRESP_s;
    logic                clr;

    logic [DW-1:0]       HRDATAm,  HRDATAm0;
    logic                HREADYm,  HREADYm0;
    logic [1:0]          HRESPm,   HRESPm0;
    logic                sel_err,  sel_err0;
    logic                tmo_err,  tmo_err0;
    logic [3:0]          tmo_slv,  tmo_slv0;

    always #5 HCLK = ~HCLK;

    ahb_rsp_mux_n #(.NSLV(NSLV), .DW(DW), .TIMEOUT(TMO)) u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
        .HRDATA_s(HRDATA_s), .HREADY_s(HREADY_s), .HRESP_s(HRESP_s), .clr(clr),
        .HRDATAm(HRDATAm), .HREADYm(HREADYm), .HRESPm(HRESPm),
        .sel_err(sel_err), .tmo_err(tmo_err), .tmo_slv(tmo_slv)
    );

    ahb_rsp_mux_n #(.NSLV(NSLV), .DW(DW), .TIMEOUT(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
        .HRDATA_s(HRDATA_s), .HREADY_s(HREADY_s), .HRESP_s(HRESP_s), .clr(clr),
        .HRDATAm(HRDATAm0), .HREADYm(HREADYm0), .HRESPm(HRESPm0),
        .sel_err(sel_err0), .tmo_err(tmo_err0), .tmo_slv(tmo_slv0)
    );

    typedef struct {
        bit          nonseq;
        logic [3:0]  hsel;
        int          waits;      // slave wait states before its final (or error) beat
        bit          serr;       // slave answers with its own two-cycle ERROR
        logic [31:0] data;
        bit          clr_after;  // pulse clr in this transfer's final cycle
    } txn_t;

    typedef struct {
        int          waits;      // HREADYm=0 cycles before completion
        logic [1:0]  resp;
        logic [31:0] data;
        bit          sel_e;
        bit          tmo_e;
        logic [3:0]  slv;
    } exp_t;

    txn_t txq[$];
    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int popc(input logic [3:0] v);
        int n = 0;
        for (int k = 0; k < 4; k++) n += int'(v[k]);
        return n;
    endfunction

    function automatic int first_idx(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return 0;
    endfunction

    function automatic txn_t mk(input bit ns, input logic [3:0] hs, input int w, input bit se,
                                input logic [31:0] d, input bit c);
        txn_t t;
        t.nonseq = ns; t.hsel = hs; t.waits = w; t.serr = se; t.data = d; t.clr_after = c;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        txn_t t;
        int   r;
        t.nonseq = ($urandom_range(0, 9) < 8);
        r = $urandom_range(0, 9);
        if (r < 6)      t.hsel = 4'b0001 << $urandom_range(0, 3);
        else if (r < 8) t.hsel = 4'b0000;
        else            t.hsel = 4'($urandom_range(0, 15));
        t.waits     = $urandom_range(0, 6);
        t.serr      = ($urandom_range(0, 6) == 0);
        t.data      = $urandom;
        t.clr_after = ($urandom_range(0, 6) == 0);
        return t;
    endfunction

    // Slave side of one data cycle: the addressed slave follows its script, the rest drive noise.
    task automatic drive_slaves(input txn_t t, input bit route, input int c);
        int k;
        for (int j = 0; j < NSLV; j++) begin
            HREADY_s[j]          = 1'($urandom_range(0, 1));
            HRESP_s[2*j +: 2]    = 2'($urandom_range(0, 1));
            HRDATA_s[j*DW +: DW] = $urandom;
        end
        if (route) begin
            k = first_idx(t.hsel);
            HREADY_s[k]          = (c >= t.waits + int'(t.serr));
            HRESP_s[2*k +: 2]    = (t.serr && c >= t.waits) ? 2'b01 : 2'b00;
            HRDATA_s[k*DW +: DW] = t.data;
        end
    endtask

    task automatic drive_addr(input txn_t t);
        HSEL   = t.hsel;
        HTRANS = {t.nonseq, 1'($urandom_range(0, 1))};
    endtask

    // Reference model: each transfer's length and completion follow from its kind alone.
    // txq[0] must be an idle transfer; it stands for the IDLE data phase that follows reset.
    task automatic run_txns();
        bit         m_sel = 1'b0;
        bit         m_tmo = 1'b0;
        logic [3:0] m_slv = 4'd0;
        bit         clr_prev = 1'b0;
        bit         route, is_err, is_tmo;
        int         low, ncyc;
        txn_t       t;
        exp_t       e;
        for (int i = 0; i < txq.size(); i++) begin
            t      = txq[i];
            route  = t.nonseq && popc(t.hsel) == 1;
            is_err = t.nonseq && popc(t.hsel) != 1;
            low    = t.waits + int'(t.serr);
            is_tmo = route && low >= TMO;

            if (clr_prev) begin m_sel = 1'b0; m_tmo = 1'b0; end
            if (t.nonseq && popc(t.hsel) > 1) m_sel = 1'b1;
            if (is_tmo) begin m_tmo = 1'b1; m_slv = 4'(first_idx(t.hsel)); end

            if (is_tmo) begin
                ncyc = TMO + 2; e.waits = TMO + 1; e.resp = 2'b01; e.data = '0;
            end else if (is_err) begin
                ncyc = 2; e.waits = 1; e.resp = 2'b01; e.data = '0;
            end else if (route) begin
                ncyc = low + 1; e.waits = low; e.resp = t.serr ? 2'b01 : 2'b00; e.data = t.data;
            end else begin
                ncyc = 1; e.waits = 0; e.resp = 2'b00; e.data = '0;
            end
            e.sel_e = m_sel; e.tmo_e = m_tmo; e.slv = m_slv;
            sbq.push_back(e);

            for (int c = 0; c < ncyc; c++) begin
                @(posedge HCLK); #1;
                drive_slaves(t, route, c);
                if (c == ncyc - 1) begin
                    if (i + 1 < txq.size()) drive_addr(txq[i+1]);
                    else begin HSEL = '0; HTRANS = 2'b00; end
                    clr = t.clr_after;
                end else begin
                    HSEL   = 4'($urandom);
                    HTRANS = 2'($urandom);
                    clr    = 1'b0;
                end
                mon_en = 1'b1;
            end
            clr_prev = t.clr_after;
        end
        @(posedge HCLK); #1;
        mon_en = 1'b0;
        clr    = 1'b0;
        HSEL   = '0;
        HTRANS = 2'b00;
    endtask

    // Monitor: count stall cycles and check each completed transfer against the scoreboard.
    initial begin : monitor
        int   low;
        exp_t e;
        low = 0;
        forever begin
            @(negedge HCLK);
            if (!mon_en) begin
                low = 0;
            end else if (!HREADYm) begin
                low++;
            end else begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_underflow: completion with no expected entry (t=%0t)", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("waits",   64'(low),     64'(e.waits));
                    chk("hresp",   64'(HRESPm),  64'(e.resp));
                    chk("hrdata",  64'(HRDATAm), 64'(e.data));
                    chk("sel_err", 64'(sel_err), 64'(e.sel_e));
                    chk("tmo_err", 64'(tmo_err), 64'(e.tmo_e));
                    chk("tmo_slv", 64'(tmo_slv), 64'(e.slv));
                end
                low = 0;
            end
        end
    end

    initial begin : guard
        #2000000;
        $display("FAIL sim_timeout: bench did not finish in time");
        $fatal(1, "bench time limit reached");
    end

    initial begin : main
        HRESETn  = 1'b0;
        HSEL     = '0;
        HTRANS   = 2'b00;
        HRDATA_s = '1;
        HREADY_s = '0;
        HRESP_s  = '1;
        clr      = 1'b0;

        #3;
        chk("rst_hready",  64'(HREADYm),  64'd1);
        chk("rst_hresp",   64'(HRESPm),   64'd0);
        chk("rst_hrdata",  64'(HRDATAm),  64'd0);
        chk("rst_sel_err", 64'(sel_err),  64'd0);
        chk("rst_tmo_err", 64'(tmo_err),  64'd0);
        chk("rst_tmo_slv", 64'(tmo_slv),  64'd0);
        chk("rst0_hready", 64'(HREADYm0), 64'd1);

        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Directed: route with waits, unmapped, multi-hot + clr, back-to-back, timeout, slave error.
        txq.push_back(mk(0, 4'b0000, 0,  0, 32'h0,         0));
        txq.push_back(mk(1, 4'b0100, 2,  0, 32'hA5A5_0002, 0));
        txq.push_back(mk(1, 4'b0000, 0,  0, 32'h0,         0));
        txq.push_back(mk(0, 4'b0000, 0,  0, 32'h0,         0));
        txq.push_back(mk(1, 4'b0011, 0,  0, 32'h0,         1));
        txq.push_back(mk(0, 4'b0000, 0,  0, 32'h0,         0));
        txq.push_back(mk(1, 4'b0001, 0,  0, 32'h1234_5678, 0));
        txq.push_back(mk(1, 4'b0000, 0,  0, 32'h0,         0));
        txq.push_back(mk(1, 4'b1000, 50, 0, 32'hDEAD_BEEF, 0));
        txq.push_back(mk(1, 4'b0010, 1,  1, 32'h0BAD_0001, 0));
        txq.push_back(mk(0, 4'b0000, 0,  0, 32'h0,         0));
        for (int i = 0; i < 250; i++) txq.push_back(rnd_txn());
        run_txns();
        chk("sb_drain", 64'(sbq.size()), 64'd0);

        // Watchdog disabled: a permanently stalled slave 3 keeps HREADYm low on the TIMEOUT=0 instance.
        HRESETn = 1'b0;
        HREADY_s = '0;
        HRESP_s  = '0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        HSEL   = 4'b1000;
        HTRANS = 2'b10;
        @(posedge HCLK); #1;
        HSEL   = '0;
        HTRANS = 2'b00;
        for (int c = 0; c < 20; c++) begin
            @(negedge HCLK);
            chk("wd_off_hready", 64'(HREADYm0), 64'd0);
        end
        chk("wd_off_tmo_err", 64'(tmo_err0), 64'd0);
        chk("wd_on_tmo_err",  64'(tmo_err),  64'd1);
        chk("wd_on_tmo_slv",  64'(tmo_slv),  64'd3);
        chk("wd_on_idle_rdy", 64'(HREADYm),  64'd1);

        // Asynchronous reset while the TIMEOUT=0 instance is stuck in ROUTE.
        HRDATA_s[3*DW +: DW] = 32'hFFFF_FFFF;
        HRESP_s[7:6]         = 2'b01;
        @(posedge HCLK); #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_hready",  64'(HREADYm0), 64'd1);
        chk("arst_hresp",   64'(HRESPm0),  64'd0);
        chk("arst_hrdata",  64'(HRDATAm0), 64'd0);
        chk("arst_tmo_err", 64'(tmo_err),  64'd0);
        chk("arst_tmo_slv", 64'(tmo_slv),  64'd0);
        @(negedge HCLK);
        @(negedge HCLK);
        chk("arst_hold_rdy",  64'(HREADYm0), 64'd1);
        chk("arst_hold_data", 64'(HRDATAm0), 64'd0);
        @(posedge HCLK); #2;
        HRESETn = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("post_rst_hready",  64'(HREADYm0), 64'd1);
        chk("post_rst_hresp",   64'(HRESPm0),  64'd0);
        chk("post_rst_hrdata",  64'(HRDATAm0), 64'd0);
        chk("post_rst_sel_err", 64'(sel_err0), 64'd0);
        chk("post_rst_tmo_err", 64'(tmo_err0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
